// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for the two-port RAM arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface ram_port_arbiter_if #(
  parameter int data_width = 8,
  parameter int addr_width = 4
);
  logic                  a_req;
  logic                  a_we;
  logic                  a_lock;
  logic [addr_width-1:0] a_addr;
  logic [data_width-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [data_width-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic                  b_lock;
  logic [addr_width-1:0] b_addr;
  logic [data_width-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [data_width-1:0] b_rdata;

  logic                  ram_we;
  logic [addr_width-1:0] ram_addr;
  logic [data_width-1:0] ram_din;
  logic [data_width-1:0] ram_dout;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between ports A and B,
// with optional bus locking bounded by MAX_BURST beats under contention.
module ram_port_arbiter #(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  state_t          state, state_n;
  port_t           last, last_n;
  logic [CW-1:0]   beat_cnt, beat_cnt_n;
  logic            gnt_a, gnt_b;
  logic            a_rvalid_q, b_rvalid_q;
  logic            mux_we;
  logic [addr_width-1:0] mux_addr;
  logic [data_width-1:0] mux_din;

  // Plain round-robin pick used in IDLE and when the owner drops its request.
  function automatic logic [1:0] idle_pick(input logic ra, input logic rb, input port_t l);
    logic [1:0] g;
    g = 2'b00;
    if (ra && rb) g = (l == PORT_B) ? 2'b10 : 2'b01;
    else          g = {ra, rb};
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= PORT_B;
      beat_cnt   <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      beat_cnt   <= beat_cnt_n;
      a_rvalid_q <= gnt_a & ~bus.a_we;
      b_rvalid_q <= gnt_b & ~bus.b_we;
    end
  end

  // Next-state: any grant re-evaluates ownership from that beat's lock bit.
  always_comb begin
    state_n    = state;
    last_n     = last;
    beat_cnt_n = beat_cnt;
    if (gnt_a) begin
      last_n = PORT_A;
      if (state == OWN_A)
        beat_cnt_n = (beat_cnt < BURST_MAX) ? beat_cnt + 1'b1 : BURST_MAX;
      else
        beat_cnt_n = CW'(1);
      state_n = bus.a_lock ? OWN_A : IDLE;
    end else if (gnt_b) begin
      last_n = PORT_B;
      if (state == OWN_B)
        beat_cnt_n = (beat_cnt < BURST_MAX) ? beat_cnt + 1'b1 : BURST_MAX;
      else
        beat_cnt_n = CW'(1);
      state_n = bus.b_lock ? OWN_B : IDLE;
    end else begin
      state_n = IDLE;
    end
  end

  // Grants and RAM command mux.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    mux_we   = 1'b0;
    mux_addr = '0;
    mux_din  = '0;
    if (!rst) begin
      case (state)
        OWN_A: begin
          if (bus.a_req) begin
            if (beat_cnt < BURST_MAX || !bus.b_req) gnt_a = 1'b1;
            else                                    gnt_b = 1'b1;
          end else begin
            {gnt_a, gnt_b} = idle_pick(bus.a_req, bus.b_req, last);
          end
        end
        OWN_B: begin
          if (bus.b_req) begin
            if (beat_cnt < BURST_MAX || !bus.a_req) gnt_b = 1'b1;
            else                                    gnt_a = 1'b1;
          end else begin
            {gnt_a, gnt_b} = idle_pick(bus.a_req, bus.b_req, last);
          end
        end
        default: {gnt_a, gnt_b} = idle_pick(bus.a_req, bus.b_req, last);
      endcase
    end
    if (gnt_a) begin
      mux_we   = bus.a_we;
      mux_addr = bus.a_addr;
      mux_din  = bus.a_wdata;
    end else if (gnt_b) begin
      mux_we   = bus.b_we;
      mux_addr = bus.b_addr;
      mux_din  = bus.b_wdata;
    end
  end

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = bus.ram_dout;
  assign bus.b_rdata  = bus.ram_dout;
  assign bus.ram_we   = mux_we;
  assign bus.ram_addr = mux_addr;
  assign bus.ram_din  = mux_din;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a port-indexed behavioural model with its own RAM image.
module tb_ram_port_arbiter;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.data_width(DW), .addr_width(AW)) bus();

  ram_port_arbiter #(.data_width(DW), .addr_width(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Single-port RAM environment: synchronous write, registered read.
  logic [DW-1:0] ram [1<<AW];
  logic ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
      ram_init_done <= 1'b1;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= ram[bus.ram_addr];
    end
  end

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model: owner is -1 (none), 0 (A) or 1 (B); last is the last granted port.
  int owner = -1;
  int cnt   = 0;
  int last  = 1;
  int e_g   = -1;
  bit e_rv [2];
  logic [DW-1:0] e_rd [2];
  logic [DW-1:0] mmem [1<<AW];

  function automatic logic [1:0] gvec(input int g);
    return (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [AW+DW:0] ram_exp(input int g);
    if (g == 0) return {bus.a_we, bus.a_addr, bus.a_wdata};
    if (g == 1) return {bus.b_we, bus.b_addr, bus.b_wdata};
    return '0;
  endfunction

  task automatic predict();
    bit r [2];
    r[0] = bus.a_req;
    r[1] = bus.b_req;
    e_g = -1;
    if (!rst) begin
      if (owner >= 0 && r[owner])
        e_g = (cnt < MAXB || !r[1-owner]) ? owner : 1 - owner;
      else if (r[0] && r[1]) e_g = 1 - last;
      else if (r[0])         e_g = 0;
      else if (r[1])         e_g = 1;
    end
  endtask

  task automatic tick();
    bit we [2];
    bit lk [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int g;
    bit r;
    we[0] = bus.a_we;   we[1] = bus.b_we;
    lk[0] = bus.a_lock; lk[1] = bus.b_lock;
    ad[0] = bus.a_addr; ad[1] = bus.b_addr;
    wd[0] = bus.a_wdata; wd[1] = bus.b_wdata;
    r = rst;
    g = e_g;
    @(posedge clk);
    cyc++;
    e_rv[0] = 1'b0;
    e_rv[1] = 1'b0;
    if (r) begin
      owner = -1; last = 1; cnt = 0;
    end else if (g >= 0) begin
      if (we[g]) mmem[ad[g]] = wd[g];
      else begin
        e_rv[g] = 1'b1;
        e_rd[g] = mmem[ad[g]];
      end
      cnt   = (owner == g) ? ((cnt < MAXB) ? cnt + 1 : MAXB) : 1;
      owner = lk[g] ? g : -1;
      last  = g;
    end else begin
      owner = -1;
    end
    #1;
  endtask

  task automatic set_a(input bit r, input bit w, input bit l,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.a_req = r; bus.a_we = w; bus.a_lock = l; bus.a_addr = ad; bus.a_wdata = wd;
  endtask

  task automatic set_b(input bit r, input bit w, input bit l,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus.b_req = r; bus.b_we = w; bus.b_lock = l; bus.b_addr = ad; bus.b_wdata = wd;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) begin
      #1; predict(); tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      set_b(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
        nerr++; $display("FAIL reset_gnt cyc=%0d got=%b exp=00", cyc, {bus.a_gnt, bus.b_gnt});
      end
      nvec++;
      if (bus.ram_we !== 1'b0) begin
        nerr++; $display("FAIL reset_ram_we cyc=%0d got=%b exp=0", cyc, bus.ram_we);
      end
      if (i > 0) begin
        nvec++;
        if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
          nerr++; $display("FAIL reset_rvalid cyc=%0d got=%b exp=00", cyc, {bus.a_rvalid, bus.b_rvalid});
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_a_alone();
    bit            w  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [AW-1:0] ad [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic [DW-1:0] wd [6] = '{8'hA5, 8'h56, 8'hB4, 8'h00, 8'h00, 8'h00};
    logic [DW-1:0] rd [3] = '{8'hA5, 8'h56, 8'hB4};
    bit rv;
    apply_reset(1);
    for (int i = 0; i < 9; i++) begin
      if (i < 6) set_a(1'b1, w[i], 1'b0, ad[i], wd[i]);
      else       set_a(1'b0, 1'b0, 1'b0, '0, '0);
      set_b(1'b0, 1'b0, 1'b0, '0, '0);
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== ((i < 6) ? 2'b10 : 2'b00)) begin
        nerr++; $display("FAIL alone_gnt cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, (i < 6) ? 2'b10 : 2'b00);
      end
      nvec++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== ram_exp(e_g)) begin
        nerr++; $display("FAIL alone_ram cyc=%0d got=%h exp=%h", cyc, {bus.ram_we, bus.ram_addr, bus.ram_din}, ram_exp(e_g));
      end
      rv = (i >= 4 && i <= 6);
      nvec++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {rv, 1'b0}) begin
        nerr++; $display("FAIL alone_rvalid cyc=%0d got=%b exp=%b", cyc, {bus.a_rvalid, bus.b_rvalid}, {rv, 1'b0});
      end
      if (rv) begin
        nvec++;
        if (bus.a_rdata !== rd[i-4]) begin
          nerr++; $display("FAIL alone_rdata cyc=%0d got=%h exp=%h", cyc, bus.a_rdata, rd[i-4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_tie_rr();
    logic [AW-1:0] aa, ba;
    logic [1:0] erv;
    int g;
    apply_reset(1);
    aa = AW'($urandom_range(0, 2));
    ba = AW'($urandom_range(0, 2));
    for (int i = 0; i < 10; i++) begin
      set_a(1'b1, 1'b0, 1'b0, aa, '0);
      set_b(1'b1, 1'b0, 1'b0, ba, '0);
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        nerr++; $display("FAIL tie_gnt cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      erv = (i == 0) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01;
      nvec++;
      if ({bus.a_rvalid, bus.b_rvalid} !== erv) begin
        nerr++; $display("FAIL tie_rvalid cyc=%0d got=%b exp=%b", cyc, {bus.a_rvalid, bus.b_rvalid}, erv);
      end
      if (e_rv[0]) begin
        nvec++;
        if (bus.a_rdata !== e_rd[0]) begin
          nerr++; $display("FAIL tie_rdata_a cyc=%0d got=%h exp=%h", cyc, bus.a_rdata, e_rd[0]);
        end
      end
      if (e_rv[1]) begin
        nvec++;
        if (bus.b_rdata !== e_rd[1]) begin
          nerr++; $display("FAIL tie_rdata_b cyc=%0d got=%h exp=%h", cyc, bus.b_rdata, e_rd[1]);
        end
      end
      g = e_g;
      tick();
      if (g == 0) aa = AW'($urandom_range(0, 2));
      if (g == 1) ba = AW'($urandom_range(0, 2));
    end
  endtask

  task automatic test_lock_burst();
    int a_left = 6;
    int bwait  = 0;
    int g;
    apply_reset(1);
    for (int i = 0; i < 14; i++) begin
      set_a(a_left > 0, 1'b0, 1'b1, AW'((6 - a_left) % 3), '0);
      set_b(1'b1, 1'b0, 1'b0, AW'(i % 3), '0);
      #1; predict();
      nvec++;
      if (i < 5) begin
        if ({bus.a_gnt, bus.b_gnt} !== ((i < 4) ? 2'b10 : 2'b01)) begin
          nerr++; $display("FAIL burst_gnt cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, (i < 4) ? 2'b10 : 2'b01);
        end
      end else if ({bus.a_gnt, bus.b_gnt} !== gvec(e_g)) begin
        nerr++; $display("FAIL burst_gnt cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, gvec(e_g));
      end
      if (bus.b_gnt !== 1'b1) bwait++;
      else                    bwait = 0;
      nvec++;
      if (bwait > MAXB) begin
        nerr++; $display("FAIL burst_bwait cyc=%0d got=%0d exp<=%0d", cyc, bwait, MAXB);
      end
      nvec++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {e_rv[0], e_rv[1]}) begin
        nerr++; $display("FAIL burst_rvalid cyc=%0d got=%b exp=%b", cyc, {bus.a_rvalid, bus.b_rvalid}, {e_rv[0], e_rv[1]});
      end
      g = e_g;
      tick();
      if (g == 0) a_left--;
    end
  endtask

  task automatic test_lock_nocontend();
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b1, (i < 7), AW'(i), DW'(8'h30 + i));
      set_b(1'b0, 1'b0, 1'b0, '0, '0);
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
        nerr++; $display("FAIL nocont_gnt cyc=%0d got=%b exp=10", cyc, {bus.a_gnt, bus.b_gnt});
      end
      nvec++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== ram_exp(e_g)) begin
        nerr++; $display("FAIL nocont_ram cyc=%0d got=%h exp=%h", cyc, {bus.ram_we, bus.ram_addr, bus.ram_din}, ram_exp(e_g));
      end
      tick();
    end
    set_a(1'b1, 1'b0, 1'b0, 4'd3, '0);
    set_b(1'b1, 1'b0, 1'b0, 4'd4, '0);
    #1; predict();
    nvec++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      nerr++; $display("FAIL nocont_tie cyc=%0d got=%b exp=01", cyc, {bus.a_gnt, bus.b_gnt});
    end
    tick();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1; predict();
    nvec++;
    if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 8'h34}) begin
      nerr++; $display("FAIL nocont_rdata cyc=%0d got=%h exp=%h", cyc, {bus.b_rvalid, bus.b_rdata}, {1'b1, 8'h34});
    end
    tick();
    // Saturated count: a long locked run must still yield at once to B.
    for (int i = 0; i < 9; i++) begin
      set_a(1'b1, 1'b0, 1'b1, AW'(i), '0);
      set_b(i == 8, 1'b0, 1'b0, 4'd5, '0);
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== ((i == 8) ? 2'b01 : 2'b10)) begin
        nerr++; $display("FAIL nocont_sat cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, (i == 8) ? 2'b01 : 2'b10);
      end
      tick();
    end
  endtask

  task automatic test_drop();
    apply_reset(1);
    set_a(1'b1, 1'b0, 1'b1, 4'd1, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1; predict();
    nvec++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      nerr++; $display("FAIL drop_own cyc=%0d got=%b exp=10", cyc, {bus.a_gnt, bus.b_gnt});
    end
    tick();
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 1'b0, 4'd2, '0);
    #1; predict();
    nvec++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      nerr++; $display("FAIL drop_gnt cyc=%0d got=%b exp=01", cyc, {bus.a_gnt, bus.b_gnt});
    end
    nvec++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b10) begin
      nerr++; $display("FAIL drop_rvalid cyc=%0d got=%b exp=10", cyc, {bus.a_rvalid, bus.b_rvalid});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset(1);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 1'b1, 4'd5, '0);
    #1; predict(); tick();
    set_a(1'b1, 1'b0, 1'b0, 4'd1, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1; predict();
    nvec++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      nerr++; $display("FAIL rmid_pre cyc=%0d got=%b exp=10", cyc, {bus.a_gnt, bus.b_gnt});
    end
    tick();
    rst = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 4'd2, '0);
    set_b(1'b1, 1'b0, 1'b1, 4'd3, '0);
    #1; predict();
    nvec++;
    if ({bus.a_gnt, bus.b_gnt, bus.ram_we} !== 3'b000) begin
      nerr++; $display("FAIL rmid_gnt cyc=%0d got=%b exp=000", cyc, {bus.a_gnt, bus.b_gnt, bus.ram_we});
    end
    nvec++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b10) begin
      nerr++; $display("FAIL rmid_rv_in cyc=%0d got=%b exp=10", cyc, {bus.a_rvalid, bus.b_rvalid});
    end
    tick();
    rst = 1'b0;
    #1; predict();
    nvec++;
    if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
      nerr++; $display("FAIL rmid_rvalid cyc=%0d got=%b exp=00", cyc, {bus.a_rvalid, bus.b_rvalid});
    end
    nvec++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      nerr++; $display("FAIL rmid_tie cyc=%0d got=%b exp=10", cyc, {bus.a_gnt, bus.b_gnt});
    end
    tick();
  endtask

  task automatic test_random();
    bit act [2];
    bit we [2];
    bit lk [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int g;
    act[0] = 1'b0; act[1] = 1'b0;
    apply_reset(1);
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) begin
          act[p] = ($urandom_range(0, 3) != 0);
          we[p]  = 1'($urandom);
          lk[p]  = 1'($urandom);
          ad[p]  = AW'($urandom);
          wd[p]  = DW'($urandom);
        end
      end
      rst = ($urandom_range(0, 79) == 0);
      set_a(act[0], we[0], lk[0], ad[0], wd[0]);
      set_b(act[1], we[1], lk[1], ad[1], wd[1]);
      #1; predict();
      nvec++;
      if ({bus.a_gnt, bus.b_gnt} !== gvec(e_g)) begin
        nerr++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {bus.a_gnt, bus.b_gnt}, gvec(e_g));
      end
      nvec++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== ram_exp(e_g)) begin
        nerr++; $display("FAIL rnd_ram cyc=%0d got=%h exp=%h", cyc, {bus.ram_we, bus.ram_addr, bus.ram_din}, ram_exp(e_g));
      end
      nvec++;
      if ({bus.a_rvalid, bus.b_rvalid} !== {e_rv[0], e_rv[1]}) begin
        nerr++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {bus.a_rvalid, bus.b_rvalid}, {e_rv[0], e_rv[1]});
      end
      if (e_rv[0]) begin
        nvec++;
        if (bus.a_rdata !== e_rd[0]) begin
          nerr++; $display("FAIL rnd_rdata_a cyc=%0d got=%h exp=%h", cyc, bus.a_rdata, e_rd[0]);
        end
      end
      if (e_rv[1]) begin
        nvec++;
        if (bus.b_rdata !== e_rd[1]) begin
          nerr++; $display("FAIL rnd_rdata_b cyc=%0d got=%h exp=%h", cyc, bus.b_rdata, e_rd[1]);
        end
      end
      g = e_g;
      tick();
      if (g >= 0) act[g] = 1'b0;
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mmem[i] = '0;
    e_rv[0] = 1'b0; e_rv[1] = 1'b0;
    e_rd[0] = '0;   e_rd[1] = '0;
    rst = 1'b1;
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_a_alone();
    test_tie_rr();
    test_lock_burst();
    test_lock_nocontend();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
